// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by both the transmitter and the receiver:
// frame state encoding, default bit-cell length and data width.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W           = 8;
    localparam int UART_CLKS_PER_BIT_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// First-word-fall-through receive FIFO. The head entry is presented on
// head_data whenever valid is high and stays put until popped.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise the byte is dropped and drop pulses for one cycle.
//
// Ports:
//   clk        - clock, rising edge
//   rst_l      - synchronous active-low reset
//   push       - write request, push_data is the byte to store
//   push_data  - write data
//   pop        - read request (ignored while empty)
//   head_data  - head entry, 0 while empty
//   valid      - FIFO non-empty
//   count      - current occupancy
//   drop       - one-cycle pulse when a push was discarded
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CNTW-1:0]  count_r;
    logic             drop_r;

    logic             full_s;
    logic             empty_s;
    logic             do_pop_s;
    logic             do_push_s;

    assign full_s    = (count_r == CNTW'(DEPTH));
    assign empty_s   = (count_r == {CNTW{1'b0}});
    assign do_pop_s  = pop && !empty_s;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push_s = push && (!full_s || do_pop_s);

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, occupancy and drop pulse. Pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CNTW{1'b0}};
            drop_r   <= 1'b0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNTW'(1);
                2'b01:   count_r <= count_r - CNTW'(1);
                default: count_r <= count_r;
            endcase
            drop_r <= push && !do_push_s;
        end
    end

    assign head_data = empty_s ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
    assign valid     = !empty_s;
    assign count     = count_r;
    assign drop      = drop_r;

endmodule

// File: rtl/uart_frame_rx.sv
// ---------------------------------------------------------------------------
// uart_frame_rx
// UART receiver: 8N1 frames, LSB first, oversampled with CLKS_PER_BIT
// system clocks per bit cell. Received bytes go into a FWFT FIFO.
//
// Ports:
//   sys_clk      - clock, rising edge
//   sys_rst_l    - synchronous active-low reset
//   uart_dataH   - asynchronous serial line, idle high
//   rx_dataH     - FIFO head byte (valid while rx_validH)
//   rx_validH    - FIFO non-empty
//   rx_readyH    - consumer accept; pop when rx_validH && rx_readyH
//   frame_errH   - one-cycle pulse when the stop bit is sampled low
//   overrunH     - one-cycle pulse when a completed byte is dropped (FIFO full)
//   fifo_countH  - FIFO occupancy
// ---------------------------------------------------------------------------
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_l,
    input  logic                          uart_dataH,
    output logic [UART_DATA_W-1:0]        rx_dataH,
    output logic                          rx_validH,
    input  logic                          rx_readyH,
    output logic                          frame_errH,
    output logic                          overrunH,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_countH
);

    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  FULL_LAST = CW'(CLKS_PER_BIT - 1);

    logic                    sync1_r;
    logic                    sync2_r;
    logic                    line_s;

    // Counts the two cycles the synchronizer needs to refill after reset.
    logic [1:0]              prime_r;
    logic                    prime_done_s;
    // Set once the line has been seen high after reset; until then a low
    // line is treated as a frame already in progress and skipped.
    logic                    armed_r;

    uart_state_e             state_r;
    uart_state_e             state_n;
    logic [CW-1:0]           cnt_r;
    logic [CW-1:0]           cnt_n;
    logic [2:0]              bit_idx_r;
    logic [2:0]              bit_idx_n;
    logic [UART_DATA_W-1:0]  shift_r;
    logic [UART_DATA_W-1:0]  shift_n;
    logic                    push_s;
    logic                    frame_err_s;
    logic                    frame_err_r;
    logic                    pop_s;

    // Two-flop synchronizer on the serial line; resets to the idle level.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_l) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= uart_dataH;
            sync2_r <= sync1_r;
        end
    end

    assign line_s       = sync2_r;
    assign prime_done_s = (prime_r == 2'd2);

    // Post-reset priming counter and idle-seen flag.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_l) begin
            prime_r <= 2'd0;
            armed_r <= 1'b0;
        end else begin
            if (!prime_done_s) begin
                prime_r <= prime_r + 2'd1;
            end else begin
                prime_r <= prime_r;
            end
            armed_r <= armed_r || (prime_done_s && line_s);
        end
    end

    // Frame FSM next-state, counters, shift register and event strobes.
    always_comb begin
        state_n     = state_r;
        cnt_n       = cnt_r + CW'(1);
        bit_idx_n   = bit_idx_r;
        shift_n     = shift_r;
        push_s      = 1'b0;
        frame_err_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_n = {CW{1'b0}};
                if (prime_done_s && !line_s) begin
                    if (armed_r) begin
                        state_n   = ST_START;
                        bit_idx_n = 3'd0;
                    end else begin
                        state_n = ST_WAIT_IDLE;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_n = {CW{1'b0}};
                    // A start bit that is already high again mid-cell was a glitch.
                    if (!line_s) begin
                        state_n = ST_DATA;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    state_n = ST_START;
                end
            end
            ST_DATA: begin
                if (cnt_r == FULL_LAST) begin
                    cnt_n     = {CW{1'b0}};
                    shift_n   = {line_s, shift_r[UART_DATA_W-1:1]};
                    bit_idx_n = bit_idx_r + 3'd1;
                    if (bit_idx_r == 3'd7) begin
                        state_n = ST_STOP;
                    end else begin
                        state_n = ST_DATA;
                    end
                end else begin
                    state_n = ST_DATA;
                end
            end
            ST_STOP: begin
                if (cnt_r == FULL_LAST) begin
                    cnt_n = {CW{1'b0}};
                    if (line_s) begin
                        push_s  = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        frame_err_s = 1'b1;
                        state_n     = ST_WAIT_IDLE;
                    end
                end else begin
                    state_n = ST_STOP;
                end
            end
            ST_WAIT_IDLE: begin
                cnt_n = {CW{1'b0}};
                if (line_s) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_WAIT_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = {CW{1'b0}};
            end
        endcase
    end

    // Frame FSM state register; reset aborts any frame in progress silently.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_l) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            bit_idx_r   <= 3'd0;
            shift_r     <= {UART_DATA_W{1'b0}};
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            cnt_r       <= cnt_n;
            bit_idx_r   <= bit_idx_n;
            shift_r     <= shift_n;
            frame_err_r <= frame_err_s;
        end
    end

    assign pop_s      = rx_validH && rx_readyH;
    assign frame_errH = frame_err_r;

    uart_rx_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (sys_clk),
        .rst_l     (sys_rst_l),
        .push      (push_s),
        .push_data (shift_r),
        .pop       (pop_s),
        .head_data (rx_dataH),
        .valid     (rx_validH),
        .count     (fifo_countH),
        .drop      (overrunH)
    );

endmodule

// File: tb/tb_uart_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_rx
// Directed bench for uart_frame_rx. A serial transmitter model drives the
// line; expected bytes are queued when sent and compared as they are popped.
// ---------------------------------------------------------------------------
module tb_uart_frame_rx;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       sys_clk    = 1'b0;
    logic       sys_rst_l  = 1'b0;
    logic       uart_dataH = 1'b1;
    logic       rx_readyH  = 1'b0;
    logic [7:0] rx_dataH;
    logic       rx_validH;
    logic       frame_errH;
    logic       overrunH;
    logic [2:0] fifo_countH;

    int         total   = 0;
    int         bad     = 0;
    int         pop_cnt = 0;
    int         err_cnt = 0;
    int         ovr_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    int         p0;
    int         e0;
    int         o0;

    uart_frame_rx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_l   (sys_rst_l),
        .uart_dataH  (uart_dataH),
        .rx_dataH    (rx_dataH),
        .rx_validH   (rx_validH),
        .rx_readyH   (rx_readyH),
        .frame_errH  (frame_errH),
        .overrunH    (overrunH),
        .fifo_countH (fifo_countH)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Serial transmitter model: start, 8 data bits LSB first, stop.
    // The line is left at the stop level afterwards.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        uart_dataH = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_dataH = b[i];
            tick(CPB);
        end
        uart_dataH = stop_bit;
        tick(CPB);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard pops and event pulse counting, away from the edge.
    always @(negedge sys_clk) begin
        if (sys_rst_l) begin
            if (rx_validH && rx_readyH) begin
                pop_cnt++;
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL unexpected_pop observed=%0h expected=none", rx_dataH);
                end
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    total++;
                    assert (rx_dataH === mon_exp) else begin
                        bad++;
                        $error("FAIL pop_data observed=%0h expected=%0h", rx_dataH, mon_exp);
                    end
                end
            end
            if (frame_errH) err_cnt++;
            if (overrunH) ovr_cnt++;
            if (frame_errH || overrunH) begin
                total++;
                assert (!(frame_errH && overrunH)) else begin
                    bad++;
                    $error("FAIL err_ovr_same_cycle observed=1 expected=0");
                end
            end
        end
    end

    initial begin
        // Reset state
        tick(5);
        check("rst_valid", rx_validH, 1'b0);
        check("rst_data", rx_dataH, 8'h00);
        check("rst_count", fifo_countH, 3'd0);
        check("rst_ferr", frame_errH, 1'b0);
        check("rst_ovr", overrunH, 1'b0);
        sys_rst_l = 1'b1;
        tick(10);

        // Single byte A5
        rx_readyH = 1'b1;
        p0 = pop_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        tick(30);
        check("a5_pops", pop_cnt - p0, 1);
        check("a5_drain", exp_q.size(), 0);
        check("a5_ferr", err_cnt, 0);
        check("a5_ovr", ovr_cnt, 0);

        // Short glitch on an idle line
        p0 = pop_cnt;
        uart_dataH = 1'b0;
        tick(5);
        uart_dataH = 1'b1;
        tick(200);
        check("glitch_pops", pop_cnt - p0, 0);
        check("glitch_count", fifo_countH, 3'd0);
        check("glitch_ferr", err_cnt, 0);

        // Framing error, line then held low well beyond a frame time
        p0 = pop_cnt;
        send_frame(8'h3C, 1'b0);
        tick(200);
        check("ferr_pulses", err_cnt, 1);
        check("ferr_count", fifo_countH, 3'd0);
        check("ferr_pops", pop_cnt - p0, 0);
        uart_dataH = 1'b1;
        tick(40);
        check("ferr_after_high", err_cnt, 1);
        check("ferr_ovr", ovr_cnt, 0);

        // Overrun: five bytes into a four-entry FIFO with no consumer
        rx_readyH = 1'b0;
        o0 = ovr_cnt;
        for (int b = 1; b <= 5; b++) begin
            if (b <= DEPTH) exp_q.push_back(8'(b));
            send_frame(8'(b), 1'b1);
            tick(4);
            if (b == 4) check("ovr_none_before5", ovr_cnt - o0, 0);
        end
        check("ovr_count_full", fifo_countH, 3'd4);
        check("ovr_pulses", ovr_cnt - o0, 1);
        check("ovr_head", rx_dataH, 8'h01);
        p0 = pop_cnt;
        rx_readyH = 1'b1;
        tick(10);
        check("ovr_drain_pops", pop_cnt - p0, 4);
        check("ovr_drain_q", exp_q.size(), 0);
        check("ovr_drain_count", fifo_countH, 3'd0);

        // Push and pop in the same cycle with the FIFO full
        rx_readyH = 1'b0;
        for (int b = 8'h10; b <= 8'h13; b++) begin
            exp_q.push_back(8'(b));
            send_frame(8'(b), 1'b1);
            tick(4);
        end
        check("sim_full", fifo_countH, 3'd4);
        o0 = ovr_cnt;
        p0 = pop_cnt;
        exp_q.push_back(8'h14);
        fork
            send_frame(8'h14, 1'b1);
            begin
                // Stop bit is sampled on the 155th edge after the start edge.
                tick(154);
                rx_readyH = 1'b1;
                tick(1);
                rx_readyH = 1'b0;
            end
        join
        tick(4);
        check("sim_count", fifo_countH, 3'd4);
        check("sim_no_ovr", ovr_cnt - o0, 0);
        check("sim_one_pop", pop_cnt - p0, 1);
        rx_readyH = 1'b1;
        tick(10);
        check("sim_drain_q", exp_q.size(), 0);
        check("sim_drain_count", fifo_countH, 3'd0);

        // Loopback bytes
        p0 = pop_cnt;
        e0 = err_cnt;
        exp_q.push_back(8'h00);
        send_frame(8'h00, 1'b1);
        tick(4);
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b1);
        tick(4);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        tick(20);
        check("loop_pops", pop_cnt - p0, 3);
        check("loop_q", exp_q.size(), 0);
        check("loop_ferr", err_cnt - e0, 0);

        // Reset in the middle of a byte whose data bits keep the line low
        p0 = pop_cnt;
        e0 = err_cnt;
        fork
            send_frame(8'h00, 1'b1);
            begin
                tick(60);
                sys_rst_l = 1'b0;
                tick(3);
                sys_rst_l = 1'b1;
            end
        join
        tick(100);
        check("rst_mid_pops", pop_cnt - p0, 0);
        check("rst_mid_count", fifo_countH, 3'd0);
        check("rst_mid_ferr", err_cnt - e0, 0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        tick(30);
        check("rst_next_pops", pop_cnt - p0, 1);
        check("rst_next_q", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
